// File: rtl/hsv_core_mem_request_pkg.sv
// hsv_core_mem_request_pkg: shared types and helpers for the mem request engine.
package hsv_core_mem_request_pkg;
  localparam int MEM_MAX_PENDING = 4;
  typedef logic [$clog2(MEM_MAX_PENDING+1)-1:0] mem_counter;
  typedef enum logic [1:0] {MEM_BYTE = 2'd0, MEM_HALF = 2'd1, MEM_WORD = 2'd2} mem_size_t;
  typedef struct packed {
    logic [4:0] rd;
    logic       write;
    mem_size_t  size;
    logic       is_unsigned;
    logic [1:0] off;
    logic       kill;
  } mem_pending_meta;
  function automatic logic [31:0] load_align(input logic [31:0] data, input logic [1:0] off,
                                             input mem_size_t size, input logic is_unsigned);
    logic [31:0] s;
    s = data >> {off, 3'b000};
    return size == MEM_BYTE ? {{24{~is_unsigned & s[7]}}, s[7:0]} :
           size == MEM_HALF ? {{16{~is_unsigned & s[15]}}, s[15:0]} : s;
  endfunction
  function automatic logic [3:0] store_strb(input mem_size_t size, input logic [1:0] off);
    return (size == MEM_BYTE ? 4'b0001 : size == MEM_HALF ? 4'b0011 : 4'b1111) << off;
  endfunction
  // aligned ops make replication equivalent to shifting into the lane
  function automatic logic [31:0] store_wdata(input logic [31:0] wdata, input mem_size_t size);
    return size == MEM_BYTE ? {4{wdata[7:0]}} : size == MEM_HALF ? {2{wdata[15:0]}} : wdata;
  endfunction
endpackage

// File: rtl/hsv_core_mem_request_if.sv
// hsv_core_mem_request_if: in-order memory bus, request and response channels.
interface hsv_core_mem_request_if;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic [31:0] bus_req_addr;
  logic        bus_req_write;
  logic [31:0] bus_req_wdata;
  logic [3:0]  bus_req_strb;
  logic        bus_resp_valid;
  logic        bus_resp_ready;
  logic [31:0] bus_resp_data;
  logic        bus_resp_error;
  modport master (
    output bus_req_valid, bus_req_addr, bus_req_write, bus_req_wdata, bus_req_strb, bus_resp_ready,
    input  bus_req_ready, bus_resp_valid, bus_resp_data, bus_resp_error
  );
  modport slave (
    input  bus_req_valid, bus_req_addr, bus_req_write, bus_req_wdata, bus_req_strb, bus_resp_ready,
    output bus_req_ready, bus_resp_valid, bus_resp_data, bus_resp_error
  );
endinterface

// File: rtl/hsv_core_mem_meta_fifo.sv
// hsv_core_mem_meta_fifo: in-order metadata FIFO with a broadcast kill of every entry.
module hsv_core_mem_meta_fifo
  import hsv_core_mem_request_pkg::*;
#(
  parameter int DEPTH = MEM_MAX_PENDING
) (
  input  logic            clk_core,
  input  logic            rst_core_n,
  input  logic            push,
  input  mem_pending_meta push_data,
  input  logic            pop,
  input  logic            kill_all,
  output mem_pending_meta head,
  output logic            full,
  output logic            empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;
  logic [AW:0] wp, rp;
  mem_pending_meta mem [DEPTH];
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign empty = wp == rp;
  assign head  = mem[rp[AW-1:0]];
  // killing free slots is harmless: a push overwrites the whole entry
  always_ff @(posedge clk_core or negedge rst_core_n)
    if (!rst_core_n) begin
      wp <= '0;
      rp <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) wp <= wp + ONE;
      if (pop) rp <= rp + ONE;
      if (push) mem[wp[AW-1:0]] <= push_data;
      if (kill_all) for (int i = 0; i < DEPTH; i++) mem[i].kill <= 1'b1;
    end
endmodule

// File: rtl/hsv_core_mem_request.sv
// hsv_core_mem_request: issues aligned loads/stores on an in-order bus and returns
// aligned, extended results to commit, throttled by the outstanding-op counter.
module hsv_core_mem_request
  import hsv_core_mem_request_pkg::*;
#(
  parameter int MAX_PENDING = MEM_MAX_PENDING
) (
  input  logic        clk_core,
  input  logic        rst_core_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_addr,
  input  logic        in_write,
  input  logic [31:0] in_wdata,
  input  logic [1:0]  in_size,
  input  logic        in_unsigned,
  input  logic [4:0]  in_rd,
  hsv_core_mem_request_if.master bus,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_rd,
  output logic [31:0] out_data,
  output logic        out_error,
  output logic        out_write,
  output logic        cnt_up,
  output logic        cnt_down,
  input  mem_counter  cnt_value
);
  mem_pending_meta head, push_meta;
  mem_size_t size;
  logic fifo_full, fifo_empty, accept, resp_fire, head_killed;
  assign size      = mem_size_t'(in_size);
  assign in_ready  = rst_core_n & ~flush & ~fifo_full & (int'(cnt_value) < MAX_PENDING) &
                     (~bus.bus_req_valid | bus.bus_req_ready);
  assign accept    = in_valid & in_ready;
  assign cnt_up    = accept;
  assign cnt_down  = out_valid & out_ready & ~flush;
  assign head_killed = ~fifo_empty & head.kill;
  assign bus.bus_resp_ready = head_killed | ~out_valid | out_ready;
  assign resp_fire = bus.bus_resp_valid & bus.bus_resp_ready;
  assign push_meta = '{rd: in_rd, write: in_write, size: size, is_unsigned: in_unsigned,
                       off: in_addr[1:0], kill: 1'b0};
  hsv_core_mem_meta_fifo #(.DEPTH(MAX_PENDING)) u_meta_fifo (
    .clk_core  (clk_core),
    .rst_core_n(rst_core_n),
    .push      (accept),
    .push_data (push_meta),
    .pop       (resp_fire),
    .kill_all  (flush),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );
  // a presented request stays put until taken, even across a flush
  always_ff @(posedge clk_core or negedge rst_core_n)
    if (!rst_core_n) begin
      bus.bus_req_valid <= 1'b0;
      bus.bus_req_addr  <= '0;
      bus.bus_req_write <= 1'b0;
      bus.bus_req_wdata <= '0;
      bus.bus_req_strb  <= '0;
    end else if (accept) begin
      bus.bus_req_valid <= 1'b1;
      bus.bus_req_addr  <= {in_addr[31:2], 2'b00};
      bus.bus_req_write <= in_write;
      bus.bus_req_wdata <= store_wdata(in_wdata, size);
      bus.bus_req_strb  <= store_strb(size, in_addr[1:0]);
    end else if (bus.bus_req_ready) bus.bus_req_valid <= 1'b0;
  always_ff @(posedge clk_core or negedge rst_core_n)
    if (!rst_core_n) begin
      out_valid <= 1'b0;
      out_rd    <= '0;
      out_data  <= '0;
      out_error <= 1'b0;
      out_write <= 1'b0;
    end else if (flush) out_valid <= 1'b0;
    else if (resp_fire && !head.kill) begin
      out_valid <= 1'b1;
      out_rd    <= head.rd;
      out_data  <= head.write ? '0 : load_align(bus.bus_resp_data, head.off, head.size, head.is_unsigned);
      out_error <= bus.bus_resp_error;
      out_write <= head.write;
    end else if (out_ready) out_valid <= 1'b0;
  resp_on_empty: assert property (@(posedge clk_core) disable iff (!rst_core_n)
    !(bus.bus_resp_valid && fifo_empty));
endmodule

// File: tb/tb_hsv_core_mem_request.sv
// tb_hsv_core_mem_request: directed and randomized checks against a queue-based model
// of the op stream, bus slave and outstanding-op counter.
`timescale 1ns/1ps
module tb_hsv_core_mem_request;
  import hsv_core_mem_request_pkg::*;
  logic clk_core = 1'b0, rst_core_n = 1'b0, flush = 1'b0;
  logic in_valid = 1'b0, in_write = 1'b0, in_unsigned = 1'b0, out_ready = 1'b0;
  logic [31:0] in_addr = '0, in_wdata = '0;
  logic [1:0] in_size = '0;
  logic [4:0] in_rd = '0;
  logic in_ready, out_valid, out_error, out_write, cnt_up, cnt_down;
  logic [4:0] out_rd;
  logic [31:0] out_data;
  mem_counter cnt_value = '0;
  hsv_core_mem_request_if bus ();
  hsv_core_mem_request #(.MAX_PENDING(4)) dut (
    .clk_core(clk_core), .rst_core_n(rst_core_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_write(in_write),
    .in_wdata(in_wdata), .in_size(in_size), .in_unsigned(in_unsigned), .in_rd(in_rd),
    .bus(bus),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd), .out_data(out_data),
    .out_error(out_error), .out_write(out_write),
    .cnt_up(cnt_up), .cnt_down(cnt_down), .cnt_value(cnt_value)
  );
  always #5 clk_core = ~clk_core;
  typedef struct {
    logic [4:0] rd; logic wr; logic [1:0] size; logic uns;
    logic [31:0] addr; logic [31:0] wdata; logic kill;
  } op_t;
  typedef struct { logic [31:0] data; logic err; int rdy; } rsp_t;
  typedef struct { logic [4:0] rd; logic [31:0] data; logic err; logic wr; } res_t;
  op_t pend[$], bus_q[$];
  rsp_t slv_q[$];
  res_t out_q[$];
  int n_cmp = 0, n_fail = 0, cyc = 0, live = 0, n_up = 0, n_down = 0, u0, d0, k;
  logic req_rdy = 1'b1, resp_en = 1'b1, rnd = 1'b0, resp_err = 1'b0;
  int resp_dly = 0;
  logic [31:0] resp_data = '0, last_data = '0, last_req_addr = '0, last_req_wdata = '0;
  logic [3:0] last_req_strb = '0;
  logic [4:0] last_rd = '0;
  logic last_write = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] d, input logic [1:0] off,
                                           input logic [1:0] size, input logic uns);
    longint n, m, v;
    n = size == 2'd0 ? 1 : size == 2'd1 ? 2 : 4;
    m = (longint'(1) << (8 * n)) - 1;
    v = longint'({32'b0, d} >> (8 * off)) & m;
    if (!uns && n < 4 && v >= (m + 1) / 2) v = v - (m + 1);
    return v[31:0];
  endfunction

  function automatic logic [3:0] ref_strb(input logic [1:0] size, input logic [1:0] off);
    int n;
    n = size == 2'd0 ? 1 : size == 2'd1 ? 2 : 4;
    return 4'(((1 << n) - 1) << off);
  endfunction

  task automatic step();
    logic exp_rdy, exp_reqv, exp_outv, exp_rrdy, acc, reqf, respf, ret;
    logic [3:0] es;
    logic [31:0] m;
    op_t o;
    rsp_t s;
    res_t r;
    @(negedge clk_core);
    cnt_value = mem_counter'(live);
    if (rnd) begin
      in_valid = 1'($urandom_range(0, 1));
      in_size = 2'($urandom_range(0, 2));
      in_addr = $urandom & ~((32'd1 << in_size) - 32'd1);
      in_write = 1'($urandom_range(0, 1));
      in_unsigned = 1'($urandom_range(0, 1));
      in_wdata = $urandom;
      in_rd = 5'($urandom_range(0, 31));
      req_rdy = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 39) == 0;
    end
    bus.bus_req_ready = req_rdy;
    bus.bus_resp_valid = resp_en && slv_q.size() != 0 && slv_q[0].rdy <= cyc;
    bus.bus_resp_data = slv_q.size() != 0 ? slv_q[0].data : 32'h0;
    bus.bus_resp_error = slv_q.size() != 0 ? slv_q[0].err : 1'b0;
    #1;
    exp_rdy = !flush && pend.size() < 4 && live < 4 && (bus_q.size() == 0 || req_rdy);
    exp_reqv = bus_q.size() != 0;
    exp_outv = out_q.size() != 0;
    exp_rrdy = (pend.size() != 0 && pend[0].kill) || !exp_outv || out_ready;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("bus_req_valid", 32'(bus.bus_req_valid), 32'(exp_reqv));
    chk("out_valid", 32'(out_valid), 32'(exp_outv));
    if (bus.bus_resp_valid) chk("bus_resp_ready", 32'(bus.bus_resp_ready), 32'(exp_rrdy));
    acc = in_valid && exp_rdy;
    reqf = exp_reqv && req_rdy;
    respf = bus.bus_resp_valid && exp_rrdy;
    ret = exp_outv && out_ready && !flush;
    chk("cnt_up", 32'(cnt_up), 32'(acc));
    chk("cnt_down", 32'(cnt_down), 32'(ret));
    n_up += int'(cnt_up);
    n_down += int'(cnt_down);
    if (reqf) begin
      o = bus_q.pop_front();
      es = ref_strb(o.size, o.addr[1:0]);
      m = '0;
      for (int b = 0; b < 4; b++) if (es[b]) m[8*b +: 8] = 8'hFF;
      chk("req_addr", bus.bus_req_addr, o.addr & ~32'd3);
      chk("req_write", 32'(bus.bus_req_write), 32'(o.wr));
      chk("req_strb", 32'(bus.bus_req_strb), 32'(es));
      if (o.wr) chk("req_wdata", bus.bus_req_wdata & m, (o.wdata << (8 * o.addr[1:0])) & m);
      last_req_addr = bus.bus_req_addr;
      last_req_wdata = bus.bus_req_wdata;
      last_req_strb = bus.bus_req_strb;
      s.data = rnd ? $urandom : resp_data;
      s.err = rnd ? $urandom_range(0, 7) == 0 : resp_err;
      s.rdy = cyc + 1 + (rnd ? int'($urandom_range(0, 3)) : resp_dly);
      slv_q.push_back(s);
    end
    if (ret) begin
      r = out_q.pop_front();
      chk("out_rd", 32'(out_rd), 32'(r.rd));
      chk("out_data", out_data, r.data);
      chk("out_error", 32'(out_error), 32'(r.err));
      chk("out_write", 32'(out_write), 32'(r.wr));
      last_data = out_data;
      last_rd = out_rd;
      last_write = out_write;
    end
    if (flush) out_q.delete();
    if (respf) begin
      o = pend.pop_front();
      s = slv_q.pop_front();
      if (!o.kill && !flush) begin
        r.rd = o.rd;
        r.wr = o.wr;
        r.err = s.err;
        r.data = o.wr ? 32'h0 : ref_load(s.data, o.addr[1:0], o.size, o.uns);
        out_q.push_back(r);
      end
    end
    if (flush) foreach (pend[i]) pend[i].kill = 1'b1;
    if (acc) begin
      o = '{rd: in_rd, wr: in_write, size: in_size, uns: in_unsigned, addr: in_addr,
            wdata: in_wdata, kill: 1'b0};
      pend.push_back(o);
      bus_q.push_back(o);
    end
    live = flush ? 0 : live + int'(acc) - int'(ret);
    cyc++;
    @(posedge clk_core);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic [1:0] sz, input logic u, input logic [4:0] rd);
    in_addr = a; in_write = w; in_wdata = d; in_size = sz; in_unsigned = u; in_rd = rd;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    bus.bus_req_ready = 1'b1;
    bus.bus_resp_valid = 1'b0;
    bus.bus_resp_data = '0;
    bus.bus_resp_error = 1'b0;
    in_valid = 1'b1;
    repeat (2) @(negedge clk_core);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_req_valid", 32'(bus.bus_req_valid), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_cnt_up", 32'(cnt_up), 32'd0);
    chk("rst_cnt_down", 32'(cnt_down), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_req_addr", bus.bus_req_addr, 32'd0);
    chk("rst_req_strb", 32'(bus.bus_req_strb), 32'd0);
    in_valid = 1'b0;
    @(negedge clk_core);
    rst_core_n = 1'b1;
    @(posedge clk_core);
    #1;
    out_ready = 1'b1; req_rdy = 1'b1; resp_en = 1'b1; resp_dly = 2;
    resp_data = 32'hDEADBEEF;
    u0 = n_up; d0 = n_down;
    issue(32'h100, 1'b0, 32'h0, 2'd2, 1'b0, 5'd7);
    run(8);
    chk("t1_data", last_data, 32'hDEADBEEF);
    chk("t1_rd", 32'(last_rd), 32'd7);
    chk("t1_up", n_up - u0, 1);
    chk("t1_down", n_down - d0, 1);
    resp_dly = 0;
    resp_data = 32'h80FFFFFF;
    issue(32'h103, 1'b0, 32'h0, 2'd0, 1'b0, 5'd1);
    run(6);
    chk("t2_signed", last_data, 32'hFFFFFF80);
    issue(32'h103, 1'b0, 32'h0, 2'd0, 1'b1, 5'd2);
    run(6);
    chk("t2_unsigned", last_data, 32'h00000080);
    issue(32'h202, 1'b1, 32'h0000ABCD, 2'd1, 1'b0, 5'd3);
    run(6);
    chk("t3_addr", last_req_addr, 32'h200);
    chk("t3_strb", 32'(last_req_strb), 32'b1100);
    chk("t3_wdata", 32'(last_req_wdata[31:16]), 32'hABCD);
    chk("t3_write", 32'(last_write), 32'd1);
    chk("t3_data", last_data, 32'd0);
    resp_en = 1'b0;
    u0 = n_up;
    for (int i = 0; i < 4; i++) issue(32'h400 + 32'(4 * i), 1'b0, 32'h0, 2'd2, 1'b0, 5'(i));
    in_addr = 32'h410; in_valid = 1'b1;
    run(4);
    chk("t4_stall", n_up - u0, 4);
    resp_en = 1'b1;
    k = 0;
    while (n_up - u0 < 5 && k < 40) begin step(); k++; end
    in_valid = 1'b0;
    chk("t4_fifth", n_up - u0, 5);
    run(12);
    out_ready = 1'b0;
    resp_data = 32'h5555AAAA;
    issue(32'h500, 1'b0, 32'h0, 2'd2, 1'b0, 5'd9);
    run(4);
    resp_en = 1'b0;
    for (int i = 0; i < 3; i++) issue(32'h504 + 32'(4 * i), 1'b0, 32'h0, 2'd2, 1'b0, 5'(10 + i));
    run(2);
    d0 = n_down;
    flush = 1'b1;
    step();
    flush = 1'b0;
    resp_en = 1'b1; out_ready = 1'b1;
    run(12);
    chk("t5_no_down", n_down - d0, 0);
    resp_data = 32'h12345678;
    issue(32'h600, 1'b0, 32'h0, 2'd2, 1'b0, 5'd14);
    run(6);
    chk("t5_after", last_data, 32'h12345678);
    chk("t5_one_down", n_down - d0, 1);
    out_ready = 1'b0;
    resp_data = 32'h11111111;
    issue(32'h700, 1'b0, 32'h0, 2'd2, 1'b0, 5'd15);
    issue(32'h704, 1'b0, 32'h0, 2'd2, 1'b0, 5'd16);
    run(4);
    d0 = n_down;
    flush = 1'b1; out_ready = 1'b1;
    step();
    flush = 1'b0;
    run(3);
    chk("t6_no_down", n_down - d0, 0);
    resp_data = 32'h33333333;
    issue(32'h708, 1'b0, 32'h0, 2'd2, 1'b0, 5'd17);
    run(6);
    chk("t6_after", last_data, 32'h33333333);
    rnd = 1'b1;
    run(600);
    rnd = 1'b0;
    in_valid = 1'b0; flush = 1'b0; req_rdy = 1'b1; out_ready = 1'b1;
    run(30);
    resp_en = 1'b0;
    issue(32'h800, 1'b0, 32'h0, 2'd2, 1'b0, 5'd18);
    issue(32'h804, 1'b0, 32'h0, 2'd2, 1'b0, 5'd19);
    @(negedge clk_core);
    rst_core_n = 1'b0;
    #1;
    chk("mid_rst_req_valid", 32'(bus.bus_req_valid), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    pend.delete(); bus_q.delete(); slv_q.delete(); out_q.delete();
    live = 0; cnt_value = '0;
    bus.bus_resp_valid = 1'b0;
    @(negedge clk_core);
    rst_core_n = 1'b1;
    @(posedge clk_core);
    #1;
    resp_en = 1'b1;
    resp_data = 32'hCAFEF00D;
    issue(32'h900, 1'b0, 32'h0, 2'd1, 1'b1, 5'd20);
    run(6);
    chk("post_rst_data", last_data, 32'h0000F00D);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/hsv_core_mem_request.md
# hsv_core_mem_request

Memory-unit request/response engine. It accepts aligned load/store ops from the mem pipeline and issues them on an in-order bus. It tracks pending ops in a metadata FIFO, aligns and extends load data, and hands results to commit. It drives the up/down pulses of the mem outstanding-op counter and uses that counter's value to throttle new ops.

## Interface
Parameters:
- MAX_PENDING, 4, maximum live ops; also the metadata FIFO depth; power of two, ≥2

Ports:
- clk_core  in  1  core clock
- rst_core_n  in  1  asynchronous, active-low reset
- flush  in  1  pipeline flush
- in_valid / in_ready  in / out  1 / 1  op handshake
- in_addr  in  32  byte address, naturally aligned
- in_write  in  1  1 = store
- in_wdata  in  32  store data, LSB-justified
- in_size  in  2  0 = byte, 1 = half, 2 = word
- in_unsigned  in  1  zero-extend load
- in_rd  in  5  destination register
- bus_req_valid / bus_req_ready  out / in  1 / 1  bus request handshake
- bus_req_addr  out  32  {in_addr[31:2], 2'b00}
- bus_req_write  out  1  store flag
- bus_req_wdata  out  32  store data shifted to byte lane
- bus_req_strb  out  4  byte enables
- bus_resp_valid / bus_resp_ready  in / out  1 / 1  response handshake; responses return in request order
- bus_resp_data  in  32  read data
- bus_resp_error  in  1  bus error
- out_valid / out_ready  out / in  1 / 1  result handshake to commit
- out_rd, out_data, out_error, out_write  out  5, 32, 1, 1  result
- cnt_up, cnt_down  out  1  counter pulses
- cnt_value  in  mem_counter  live-op count

## Operation
- Accept: in_ready = ~flush & ~fifo_full & (cnt_value < MAX_PENDING) & (~bus_req_valid | bus_req_ready).
- On accept:
  - load the bus request register;
  - push {rd, write, size, unsigned, addr[1:0], kill=0} into the FIFO;
  - pulse cnt_up.
- Store shaping:
  - wdata is replicated/shifted to lane addr[1:0];
  - strb = 0001 / 0011 / 1111 for size 0 / 1 / 2, shifted left by addr[1:0].
- A presented bus request is held stable until its handshake; flush does not withdraw it.
- Response path: bus_resp_ready = head_killed | ~out_valid | out_ready. Each response pops the FIFO head.
  - Killed head: the response is dropped, with no output and no cnt_down.
  - Live head: load the output register.
    - Loads: data >> (8·addr[1:0]), then sign- or zero-extend from 8 or 16 bits per size/unsigned.
    - Stores: out_data = 0.
    - out_error = bus_resp_error.
- Retire: out_valid & out_ready & ~flush pulses cnt_down and clears out_valid, unless it is refilled in the same cycle.
- Flush (priority over all else):
  - every valid FIFO entry gets kill=1;
  - out_valid clears with no cnt_down;
  - no accept that cycle.
  - The counter resets itself on the same flush. Killed entries still occupy the FIFO until their responses drain, and fifo_full throttles accordingly.

## Timing
- Reset values: in_ready 0 while in reset; bus_req_valid 0, out_valid 0, cnt_up 0, cnt_down 0, FIFO empty, all data outputs 0.
- in accept → bus_req_valid: 1 cycle.
- bus response handshake → out_valid: 1 cycle.
- Full rate: one op per cycle with back-to-back bus readiness.
- cnt_up and cnt_down are combinational from their handshakes and may both be 1 in one cycle.
- A response and a push in the same cycle with a full FIFO is legal: the pop frees the slot, but in_ready uses pre-pop full (no bypass).
- FIFO pointers are log2(MAX_PENDING)+1 bits wide. Full means MSBs differ and LSBs are equal; pointers wrap naturally.
- A response arriving with the FIFO empty is a protocol violation and gets an assertion.
- Reset mid-transaction clears all state. The bus is reset alongside.

## Structure
- Shared package: mem_counter (width $clog2(MAX_PENDING+1)), mem_size_t enum, and the mem_pending_meta struct.
- Natural sub-module: hsv_core_mem_meta_fifo, a parameterised in-order FIFO with a broadcast kill-all input.
- Load align/extend is a function in the package.

## Test plan
- Load word at 0x100; bus returns 0xDEADBEEF after 3 cycles → out_valid 1 cycle later, out_data 0xDEADBEEF, out_rd matches; exactly one cnt_up and one cnt_down.
- Signed byte load at 0x103 returning 0x80FFFFFF → 0xFFFFFF80. The unsigned version → 0x00000080.
- Store half 0xABCD at 0x202 → bus_req_addr 0x200, strb 1100, wdata[31:16] = 0xABCD; out_write 1.
- Hold bus_resp_valid 0 and issue 5 ops with MAX_PENDING = 4 → the 5th stalls (in_ready 0) until the first response retires.
- Three ops in flight, flush asserted → out_valid 0; the next three responses are consumed with no out_valid and no cnt_down. A new op accepted after the flush returns normally.
- Flush in the same cycle as out_valid & out_ready and a bus response → no cnt_down, the response is dropped, and the FIFO pop is still performed.
